// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared widths, metadata field offsets and read-side state type
// META_W : packed {remote_ip, remote_port, local_port}
// DATA_W : packed {tlast, tkeep, tdata}
package udp_tx_pkg;
  localparam int META_W = 64;
  localparam int IP_LSB = 32;
  localparam int RPORT_LSB = 16;
  localparam int LPORT_LSB = 0;
  localparam int DATA_W = 577;
  localparam int KEEP_LSB = 512;
  localparam int LAST_BIT = 576;
  typedef enum logic {IDLE, SEND} rd_state_t;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port, one read port with 1-cycle registered read
// clk/rst : clock, sync active-high reset (clears the read register only)
// we/waddr/wdata : write port
// re/raddr/rdata : read port, rdata updates only when re is high
module sdp_ram #(
  parameter int W = 8,
  parameter int D = 16,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/udp_tx_pkt_buffer.sv
// udp_tx_pkt_buffer: store-and-forward UDP transmit buffer with whole-packet drop on overflow
// s_axis_* / s_remote_ip / s_remote_port / s_local_port : non-stalling input stream, metadata on first beat
// m_axis_* / remote_ip_tx / remote_port_tx / local_port_tx : backpressured output stream with per-packet metadata
// drop_count / overflow : saturating drop counter and one-cycle drop pulse
module udp_tx_pkt_buffer
  import udp_tx_pkg::*;
#(
  parameter int DATA_DEPTH = 128,
  parameter int META_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tvalid,
  input  logic [31:0]  s_remote_ip,
  input  logic [15:0]  s_remote_port,
  input  logic [15:0]  s_local_port,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [31:0]  remote_ip_tx,
  output logic [15:0]  remote_port_tx,
  output logic [15:0]  local_port_tx,
  output logic [31:0]  drop_count,
  output logic         overflow
);
  localparam int DA = $clog2(DATA_DEPTH);
  localparam int MA = $clog2(META_DEPTH);
  logic [DA:0] wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [MA:0] meta_wr_q, meta_wr_d, meta_ra_q, meta_ra_d, meta_rel_q, meta_rel_d;
  logic [META_W-1:0] meta_lat_q, meta_lat_d, meta_in, meta_push, meta_rd;
  logic [DATA_W-1:0] data_rd;
  logic [31:0] drop_q, drop_d;
  logic in_pkt_q, in_pkt_d, good_q, good_d, tvalid_q, tvalid_d, overflow_q, overflow_d;
  rd_state_t state_q, state_d;
  logic first, data_full, meta_full, pkt_ok, wr_en, commit, drop;
  logic meta_pend, hs, last_hs, start, data_re;
  always_comb begin
    first = s_axis_tvalid & ~in_pkt_q;
    data_full = (wr_spec_q[DA-1:0] == rd_ptr_q[DA-1:0]) & (wr_spec_q[DA] != rd_ptr_q[DA]);
    // meta entries are held until their packet's tlast handshake, not just until popped
    meta_full = (meta_wr_q[MA-1:0] == meta_rel_q[MA-1:0]) & (meta_wr_q[MA] != meta_rel_q[MA]);
    pkt_ok = first ? ~meta_full : good_q;
    wr_en = s_axis_tvalid & pkt_ok & ~data_full;
    commit = wr_en & s_axis_tlast;
    drop = s_axis_tvalid & s_axis_tlast & ~wr_en;
    meta_in = {s_remote_ip, s_remote_port, s_local_port};
    meta_push = first ? meta_in : meta_lat_q;
    meta_lat_d = first ? meta_in : meta_lat_q;
    in_pkt_d = s_axis_tvalid ? ~s_axis_tlast : in_pkt_q;
    good_d = s_axis_tvalid ? wr_en : good_q;
    wr_spec_d = drop ? wr_commit_q : wr_en ? wr_spec_q + (DA+1)'(1) : wr_spec_q;
    wr_commit_d = commit ? wr_spec_q + (DA+1)'(1) : wr_commit_q;
    meta_wr_d = commit ? meta_wr_q + (MA+1)'(1) : meta_wr_q;
    overflow_d = drop;
    drop_d = (drop & ~&drop_q) ? drop_q + 32'd1 : drop_q;
    meta_pend = meta_wr_q != meta_ra_q;
    hs = tvalid_q & m_axis_tready;
    last_hs = hs & data_rd[LAST_BIT];
    // a finishing packet hands straight over to the next pending one
    start = (state_q == IDLE | last_hs) & meta_pend;
    data_re = start | (hs & ~data_rd[LAST_BIT]);
    rd_ptr_d = data_re ? rd_ptr_q + (DA+1)'(1) : rd_ptr_q;
    meta_ra_d = start ? meta_ra_q + (MA+1)'(1) : meta_ra_q;
    meta_rel_d = last_hs ? meta_rel_q + (MA+1)'(1) : meta_rel_q;
    state_d = start ? SEND : last_hs ? IDLE : state_q;
    tvalid_d = start | (tvalid_q & ~last_hs);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_spec_q <= '0;
      wr_commit_q <= '0;
      rd_ptr_q <= '0;
      meta_wr_q <= '0;
      meta_ra_q <= '0;
      meta_rel_q <= '0;
      meta_lat_q <= '0;
      drop_q <= '0;
      in_pkt_q <= 1'b0;
      good_q <= 1'b0;
      tvalid_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      wr_spec_q <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q <= rd_ptr_d;
      meta_wr_q <= meta_wr_d;
      meta_ra_q <= meta_ra_d;
      meta_rel_q <= meta_rel_d;
      meta_lat_q <= meta_lat_d;
      drop_q <= drop_d;
      in_pkt_q <= in_pkt_d;
      good_q <= good_d;
      tvalid_q <= tvalid_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
    end
  end
  sdp_ram #(.W(DATA_W), .D(DATA_DEPTH)) u_data (
    .clk(clk), .rst(rst),
    .we(wr_en), .waddr(wr_spec_q[DA-1:0]), .wdata({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re(data_re), .raddr(rd_ptr_q[DA-1:0]), .rdata(data_rd)
  );
  sdp_ram #(.W(META_W), .D(META_DEPTH)) u_meta (
    .clk(clk), .rst(rst),
    .we(commit), .waddr(meta_wr_q[MA-1:0]), .wdata(meta_push),
    .re(start), .raddr(meta_ra_q[MA-1:0]), .rdata(meta_rd)
  );
  assign m_axis_tdata = data_rd[KEEP_LSB-1:0];
  assign m_axis_tkeep = data_rd[LAST_BIT-1:KEEP_LSB];
  assign m_axis_tlast = data_rd[LAST_BIT];
  assign m_axis_tvalid = tvalid_q;
  assign remote_ip_tx = meta_rd[IP_LSB +: 32];
  assign remote_port_tx = meta_rd[RPORT_LSB +: 16];
  assign local_port_tx = meta_rd[LPORT_LSB +: 16];
  assign drop_count = drop_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_udp_tx_pkt_buffer.sv
// tb_udp_tx_pkt_buffer: directed self-checking bench for udp_tx_pkt_buffer (DATA_DEPTH=8, META_DEPTH=2)
module tb_udp_tx_pkt_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] s_tdata = '0;
  logic [63:0] s_tkeep = '0;
  logic s_tlast = 1'b0, s_tvalid = 1'b0;
  logic [31:0] s_ip = '0;
  logic [15:0] s_rport = '0, s_lport = '0;
  logic [511:0] m_tdata;
  logic [63:0] m_tkeep;
  logic m_tlast, m_tvalid;
  logic m_tready = 1'b0;
  logic [31:0] ip_tx, drop_count;
  logic [15:0] rport_tx, lport_tx;
  logic overflow;
  int cyc = 0, pass_n = 0, chk_n = 0, exp_drop = 0, lg_n = 0, ovf_n = 0;
  logic [511:0] lg_data [64];
  logic [63:0] lg_keep [64];
  logic [63:0] lg_meta [64];
  logic lg_last [64];
  int lg_cyc [64];
  always #5 clk = ~clk;
  udp_tx_pkt_buffer #(.DATA_DEPTH(8), .META_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_remote_ip(s_ip), .s_remote_port(s_rport), .s_local_port(s_lport),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .remote_ip_tx(ip_tx), .remote_port_tx(rport_tx), .local_port_tx(lport_tx),
    .drop_count(drop_count), .overflow(overflow)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready && lg_n < 64) begin
      lg_data[lg_n] <= m_tdata;
      lg_keep[lg_n] <= m_tkeep;
      lg_last[lg_n] <= m_tlast;
      lg_meta[lg_n] <= {ip_tx, rport_tx, lport_tx};
      lg_cyc[lg_n] <= cyc;
      lg_n <= lg_n + 1;
    end
    if (overflow) ovf_n <= ovf_n + 1;
  end
  function automatic logic [511:0] mkd(input int id, input int b);
    logic [31:0] w;
    w = {id[15:0], b[15:0]};
    return {16{w}};
  endfunction
  function automatic logic [63:0] mkk(input logic last);
    return last ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] mkm(input int id);
    return {32'h0A00_0000 + id, 16'h1233 + id[15:0], 16'h2541 + id[15:0]};
  endfunction
  task automatic send_pkt(input int id, input int n, input int nsend, output int tc);
    for (int b = 0; b < nsend; b++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata = mkd(id, b);
      s_tkeep = mkk(b == n - 1);
      s_tlast = (b == n - 1);
      {s_ip, s_rport, s_lport} = (b == 0) ? mkm(id) : ~mkm(id);
      tc = cyc;
    end
  endtask
  task automatic idle();
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_n++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep} !== '0) $display("FAIL reset_stream: got valid=%b last=%b keep=%h want all 0", m_tvalid, m_tlast, m_tkeep);
    else pass_n++;
    chk_n++;
    if ({ip_tx, rport_tx, lport_tx, drop_count, overflow} !== '0) $display("FAIL reset_meta: got ip=%h rp=%h lp=%h drop=%0d ovf=%b want 0", ip_tx, rport_tx, lport_tx, drop_count, overflow);
    else pass_n++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_single;
    int tc, base;
    base = lg_n;
    m_tready = 1'b1;
    send_pkt(1, 3, 3, tc);
    idle();
    wait_cyc(8);
    chk_n++;
    if (lg_n - base !== 3) $display("FAIL single_count: got %0d beats want 3", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 3; i++) begin
      chk_n++;
      if (lg_data[base+i] !== mkd(1, i) || lg_keep[base+i] !== mkk(i == 2) || lg_last[base+i] !== (i == 2))
        $display("FAIL single_beat%0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b", i, lg_data[base+i][31:0], lg_keep[base+i], lg_last[base+i], mkd(1, i)[31:0], mkk(i == 2), i == 2);
      else pass_n++;
      chk_n++;
      if (lg_cyc[base+i] !== tc + 2 + i || lg_meta[base+i] !== mkm(1))
        $display("FAIL single_timing%0d: got cyc=%0d meta=%h want cyc=%0d meta=%h", i, lg_cyc[base+i], lg_meta[base+i], tc + 2 + i, mkm(1));
      else pass_n++;
    end
  endtask
  task automatic test_back_to_back;
    int tc, base, hs_cnt, idle_n;
    logic prev_stall;
    logic [511:0] prev_data;
    logic [63:0] prev_meta;
    base = lg_n;
    hs_cnt = 0;
    idle_n = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_meta = '0;
    m_tready = 1'b0;
    send_pkt(2, 2, 2, tc);
    send_pkt(3, 1, 1, tc);
    idle();
    wait_cyc(4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      m_tready = (i % 2 == 0);
      @(negedge clk);
      if (prev_stall) begin
        chk_n++;
        if (m_tvalid !== 1'b1 || m_tdata !== prev_data || {ip_tx, rport_tx, lport_tx} !== prev_meta)
          $display("FAIL b2b_stall: got valid=%b data=%h meta=%h want valid=1 data=%h meta=%h", m_tvalid, m_tdata[31:0], {ip_tx, rport_tx, lport_tx}, prev_data[31:0], prev_meta);
        else pass_n++;
      end
      if (hs_cnt > 0 && hs_cnt < 3 && !m_tvalid) idle_n++;
      if (m_tvalid && m_tready) hs_cnt++;
      prev_stall = m_tvalid & ~m_tready;
      prev_data = m_tdata;
      prev_meta = {ip_tx, rport_tx, lport_tx};
    end
    m_tready = 1'b1;
    wait_cyc(4);
    chk_n++;
    if (lg_n - base !== 3) $display("FAIL b2b_count: got %0d beats want 3", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 3; i++) begin
      chk_n++;
      if (lg_data[base+i] !== mkd(i < 2 ? 2 : 3, i < 2 ? i : 0) || lg_last[base+i] !== (i != 0) || lg_meta[base+i] !== mkm(i < 2 ? 2 : 3))
        $display("FAIL b2b_beat%0d: got data=%h last=%b meta=%h want data=%h last=%b meta=%h", i, lg_data[base+i][31:0], lg_last[base+i], lg_meta[base+i], mkd(i < 2 ? 2 : 3, i < 2 ? i : 0)[31:0], i != 0, mkm(i < 2 ? 2 : 3));
      else pass_n++;
    end
    chk_n++;
    if (idle_n > 1) $display("FAIL b2b_gap: got %0d idle cycles want at most 1", idle_n);
    else pass_n++;
  endtask
  task automatic test_data_overflow;
    int tc, base, o0, bad;
    base = lg_n;
    o0 = ovf_n;
    bad = 0;
    m_tready = 1'b0;
    send_pkt(4, 5, 5, tc);
    send_pkt(5, 5, 5, tc);
    idle();
    @(negedge clk);
    chk_n++;
    if (overflow !== 1'b1) $display("FAIL dovf_pulse: got overflow=%b want 1", overflow);
    else pass_n++;
    exp_drop++;
    @(negedge clk);
    chk_n++;
    if (overflow !== 1'b0 || drop_count !== exp_drop) $display("FAIL dovf_after: got overflow=%b drop=%0d want 0 and %0d", overflow, drop_count, exp_drop);
    else pass_n++;
    m_tready = 1'b1;
    wait_cyc(12);
    chk_n++;
    if (lg_n - base !== 5) $display("FAIL dovf_count: got %0d beats want 5", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 5; i++)
      if (lg_data[base+i] !== mkd(4, i) || lg_last[base+i] !== (i == 4) || lg_meta[base+i] !== mkm(4)) bad++;
    chk_n++;
    if (bad != 0) $display("FAIL dovf_data: got %0d wrong beats want 0", bad);
    else pass_n++;
    chk_n++;
    if (ovf_n - o0 !== 1) $display("FAIL dovf_pulses: got %0d pulses want 1", ovf_n - o0);
    else pass_n++;
  endtask
  task automatic test_meta_overflow;
    int tc, base, o0;
    base = lg_n;
    o0 = ovf_n;
    m_tready = 1'b0;
    send_pkt(6, 1, 1, tc);
    send_pkt(7, 1, 1, tc);
    send_pkt(8, 1, 1, tc);
    idle();
    @(negedge clk);
    exp_drop++;
    chk_n++;
    if (overflow !== 1'b1 || drop_count !== exp_drop) $display("FAIL movf_pulse: got overflow=%b drop=%0d want 1 and %0d", overflow, drop_count, exp_drop);
    else pass_n++;
    m_tready = 1'b1;
    wait_cyc(10);
    chk_n++;
    if (lg_n - base !== 2) $display("FAIL movf_count: got %0d packets want 2", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 2; i++) begin
      chk_n++;
      if (lg_data[base+i] !== mkd(6 + i, 0) || lg_last[base+i] !== 1'b1 || lg_meta[base+i] !== mkm(6 + i))
        $display("FAIL movf_pkt%0d: got data=%h meta=%h want data=%h meta=%h", i, lg_data[base+i][31:0], lg_meta[base+i], mkd(6 + i, 0)[31:0], mkm(6 + i));
      else pass_n++;
    end
    chk_n++;
    if (ovf_n - o0 !== 1) $display("FAIL movf_pulses: got %0d pulses want 1", ovf_n - o0);
    else pass_n++;
  endtask
  task automatic test_long_pkt;
    int tc, base;
    base = lg_n;
    m_tready = 1'b1;
    send_pkt(9, 9, 9, tc);
    idle();
    @(negedge clk);
    exp_drop++;
    chk_n++;
    if (overflow !== 1'b1 || drop_count !== exp_drop) $display("FAIL long_drop: got overflow=%b drop=%0d want 1 and %0d", overflow, drop_count, exp_drop);
    else pass_n++;
    send_pkt(10, 2, 2, tc);
    idle();
    wait_cyc(8);
    chk_n++;
    if (lg_n - base !== 2) $display("FAIL long_count: got %0d beats want 2", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 2; i++) begin
      chk_n++;
      if (lg_data[base+i] !== mkd(10, i) || lg_last[base+i] !== (i == 1) || lg_meta[base+i] !== mkm(10) || lg_cyc[base+i] !== tc + 2 + i)
        $display("FAIL long_next%0d: got data=%h last=%b meta=%h cyc=%0d want data=%h last=%b meta=%h cyc=%0d", i, lg_data[base+i][31:0], lg_last[base+i], lg_meta[base+i], lg_cyc[base+i], mkd(10, i)[31:0], i == 1, mkm(10), tc + 2 + i);
      else pass_n++;
    end
  endtask
  task automatic test_reset_mid;
    int tc, base;
    m_tready = 1'b0;
    send_pkt(11, 1, 1, tc);
    idle();
    wait_cyc(3);
    send_pkt(13, 4, 2, tc);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    chk_n++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep} !== '0) $display("FAIL rmid_stream: got valid=%b last=%b data=%h want all 0", m_tvalid, m_tlast, m_tdata[31:0]);
    else pass_n++;
    chk_n++;
    if ({ip_tx, rport_tx, lport_tx, drop_count, overflow} !== '0) $display("FAIL rmid_meta: got ip=%h drop=%0d ovf=%b want 0", ip_tx, drop_count, overflow);
    else pass_n++;
    base = lg_n;
    m_tready = 1'b1;
    send_pkt(12, 2, 2, tc);
    idle();
    wait_cyc(10);
    chk_n++;
    if (lg_n - base !== 2) $display("FAIL rmid_count: got %0d beats want 2", lg_n - base);
    else pass_n++;
    for (int i = 0; i < 2; i++) begin
      chk_n++;
      if (lg_data[base+i] !== mkd(12, i) || lg_last[base+i] !== (i == 1) || lg_meta[base+i] !== mkm(12) || lg_cyc[base+i] !== tc + 2 + i)
        $display("FAIL rmid_pkt%0d: got data=%h meta=%h cyc=%0d want data=%h meta=%h cyc=%0d", i, lg_data[base+i][31:0], lg_meta[base+i], lg_cyc[base+i], mkd(12, i)[31:0], mkm(12), tc + 2 + i);
      else pass_n++;
    end
    chk_n++;
    if (drop_count !== exp_drop) $display("FAIL rmid_drop: got %0d want %0d", drop_count, exp_drop);
    else pass_n++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_data_overflow;
    test_meta_overflow;
    test_long_pkt;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule

// File: doc/udp_tx_pkt_buffer.md
# udp_tx_pkt_buffer

Store-and-forward transmit buffer between the XVC controller's non-backpressured response stream (`m_axis_*`, `remote_ip_tx`, `remote_port_tx`, `local_port_tx`) and the UDP transmit path of the network stack, which applies `tready` backpressure. It captures per-packet UDP metadata at the first beat and stores whole packets. It releases a packet only once its `tlast` has been written. Packets that cannot fit are dropped whole and counted.

## Interface
- `DATA_DEPTH`, 128: data buffer depth in 512-bit beats; power of two, at least 2.
- `META_DEPTH`, 16: metadata buffer depth in packets; power of two, at least 2.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 512: input beat data.
- `s_axis_tkeep` in 64: input byte enables.
- `s_axis_tlast` in 1: input end of packet.
- `s_axis_tvalid` in 1: input beat valid. There is no `tready`; the input never stalls.
- `s_remote_ip` in 32: remote IP. Sampled on the first beat of a packet.
- `s_remote_port` in 16: remote port. Sampled on the first beat of a packet.
- `s_local_port` in 16: local port. Sampled on the first beat of a packet.
- `m_axis_tdata` out 512: output beat data.
- `m_axis_tkeep` out 64: output byte enables.
- `m_axis_tlast` out 1: output end of packet.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: output ready.
- `remote_ip_tx` out 32: remote IP of the packet currently being output.
- `remote_port_tx` out 16: remote port of the packet currently being output.
- `local_port_tx` out 16: local port of the packet currently being output.
- `drop_count` out 32: number of dropped packets; saturates at `32'hFFFF_FFFF`.
- `overflow` out 1: one-cycle pulse for each dropped packet.

## Operation
- **Write side, packet tracking**
  - An `in_pkt` flag is set by any valid beat without `tlast` and cleared by a valid beat with `tlast`.
  - The first beat is a valid beat while `in_pkt` is 0.
- **First beat**
  - If the metadata buffer has a free entry, the first beat latches the metadata and the packet is marked good.
  - If the metadata buffer is full, the packet is marked bad.
- **Every valid beat**
  - If the packet is good and the data buffer is not full, the beat is written at the speculative write pointer `wr_spec`.
  - Otherwise the packet is marked bad and the beat is discarded.
  - Full is evaluated against `rd_ptr` in the same cycle, so a concurrent read does not free space for that cycle's write.
- **`tlast` beat, good packet**
  - `wr_commit` is set to `wr_spec` plus 1.
  - The metadata `{ip, rport, lport}` is pushed.
- **`tlast` beat, bad packet**
  - `wr_spec` is set back to `wr_commit`.
  - Nothing is pushed.
  - `overflow` pulses and `drop_count` increments.
- **Packet size limits**
  - A packet longer than `DATA_DEPTH` is always dropped.
  - A single-beat packet (first beat with `tlast`) is legal.
- **Read-side states:** `IDLE` and `SEND`.
  - `IDLE` to `SEND`: when the metadata buffer is non-empty, pop one entry into the `*_tx` registers and start prefetching data from `rd_ptr`.
  - `SEND` to `IDLE`: on the handshake of the `tlast` beat. If more metadata is pending, `SEND` restarts directly.
  - The `*_tx` outputs stay stable from the first `tvalid` of a packet through its `tlast` handshake.
- **Output handshake**
  - `m_axis_tvalid` is never retracted before the handshake.
  - Data, keep and last stay stable while `tvalid` is high and `tready` is low.
- **Pointers**
  - All pointers are `log2(DEPTH)+1` bits, with the top bit as the wrap bit.
  - Full means the index bits are equal and the wrap bits differ.
  - Empty means the pointers are equal.
  - Pointers wrap naturally.
- **Ordering:** packets are output in commit order. The output never shows partial or dropped packets.

## Timing
- **Reset values**
  - All outputs are 0, including `m_axis_*`, `*_tx`, `drop_count` and `overflow`.
  - All pointers, `in_pkt` and the state register are cleared. The state is `IDLE`.
- **Reset mid-packet:** all stored and partial packets are lost. The first valid beat after reset is a first beat.
- **Commit-to-output latency:** `tlast` written at cycle N with the read side idle gives `m_axis_tvalid` high at N+2, with metadata valid in the same cycle.
- **Throughput within a packet:** one beat per cycle while `tready` is high, with no bubbles.
- **Between packets:** at most one idle cycle.
- **Drop indication:** `overflow` is high and `drop_count` is updated in cycle N+1 after the `tlast` cycle N.
- **Simultaneous events**
  - A metadata push and pop in the same cycle are both honoured. The count is unchanged.
  - A commit at N is not visible to the read side before N+1.

## Structure
- Package `udp_tx_pkg`:
  - `META_W = 64` and the metadata field offsets.
  - The `rd_state_t` enum for `IDLE` and `SEND`.
- Sub-module `sdp_ram`: simple dual-port RAM with one write port and one read port, 1-cycle registered read, parameterized width and depth.
  - Instantiated twice: data at 577 bits (`tdata`, `tkeep`, `tlast`) and metadata at 64 bits.

## Test plan
- Single 3-beat packet, IP `0A000001`, ports `1234`/`2542`, `tready`=1, `tlast` at cycle 10:
  - `tvalid` at cycles 12–14 with identical data.
  - `*_tx` equal to the input metadata.
  - `tlast` on the third beat.
- Two back-to-back packets of 2 beats and 1 beat, with `tready` toggling 1010:
  - Data held stable while stalled.
  - Metadata switches only after the first packet's `tlast` handshake.
  - At most 1 idle cycle between packets.
- `DATA_DEPTH`=8, `tready`=0, send packets of 5 beats then 5 beats:
  - The second packet is dropped, with `overflow` pulsing once and `drop_count` reaching 1.
  - After `tready`=1, only the first packet appears.
- `META_DEPTH`=2, `tready`=0, send three 1-beat packets:
  - The third is dropped and `drop_count` is 1.
  - The output later shows exactly two packets.
- Reset asserted mid-way through a 4-beat packet with one packet stored:
  - All outputs are 0 on the next cycle.
  - A new packet after reset is output correctly and nothing stale appears.
- A 9-beat packet with `DATA_DEPTH`=8 and an empty buffer:
  - The packet is dropped.
  - A following 2-beat packet is output intact, confirming the pointer rollback.
